// File: rtl/register_file_32_by_32_pkg.sv
// Shared constants and types for the 32x32 register file.
package register_file_32_by_32_pkg;

    localparam int          REG_DATA_WIDTH  = 32;
    localparam int          REG_ADDR_WIDTH  = 5;
    localparam logic [4:0]  REG_ZERO        = 5'd0;
    localparam logic [31:0] REG_RESET_VALUE = 32'h0;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/register_file_32_by_32_cells.sv
// Leaf cells: load-enabled data register with async active-high reset, and a 2:1 data mux.
module register_32_bits
    import register_file_32_by_32_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= DATA_WIDTH'(REG_RESET_VALUE);
        end else if (load) begin
            q <= d;
        end
    end

endmodule

module mux_2_to_1_32 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] d0,
    input  logic [DATA_WIDTH-1:0] d1,
    output logic [DATA_WIDTH-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/register_file_32_by_32.sv
// 32x32 register file: two combinational read ports, one synchronous write port, r0 tied to zero.
module register_file_32_by_32
    import register_file_32_by_32_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NODES = 2 * DEPTH - 1;

    logic [DEPTH-1:0]      write_en;
    logic [DATA_WIDTH-1:0] entry [DEPTH];
    logic [ADDR_WIDTH-1:0] read_addr [2];
    logic [DATA_WIDTH-1:0] node      [2][NODES];
    logic [DATA_WIDTH-1:0] raw_data  [2];
    logic [DATA_WIDTH-1:0] port_data [2];

    assign read_addr[0] = read_addr_1;
    assign read_addr[1] = read_addr_2;

    assign entry[0]    = DATA_WIDTH'(REG_RESET_VALUE);
    assign write_en[0] = 1'b0;

    // Enable is ANDed with reg_write so an unknown address with writes off cannot load anything.
    genvar i;
    generate
        for (i = 1; i < DEPTH; i++) begin : g_entry
            assign write_en[i] = reg_write && (write_addr == ADDR_WIDTH'(i));

            register_32_bits #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_reg (
                .clk   (clk),
                .reset (reset),
                .load  (write_en[i]),
                .d     (write_data),
                .q     (entry[i])
            );
        end
    endgenerate

    // Heap-ordered mux tree per port: node n has children 2n+1 / 2n+2, leaves sit at DEPTH-1+k,
    // and the root level is steered by the address MSB.
    genvar p, lvl, k;
    generate
        for (p = 0; p < 2; p++) begin : g_port
            for (k = 0; k < DEPTH; k++) begin : g_leaf
                assign node[p][DEPTH-1+k] = entry[k];
            end

            for (lvl = 0; lvl < ADDR_WIDTH; lvl++) begin : g_level
                for (k = 0; k < (1 << lvl); k++) begin : g_node
                    localparam int N = (1 << lvl) - 1 + k;

                    mux_2_to_1_32 #(
                        .DATA_WIDTH (DATA_WIDTH)
                    ) u_mux (
                        .sel (read_addr[p][ADDR_WIDTH-1-lvl]),
                        .d0  (node[p][2*N+1]),
                        .d1  (node[p][2*N+2]),
                        .y   (node[p][N])
                    );
                end
            end

            assign raw_data[p] = node[p][0];

            always_comb begin
                port_data[p] = raw_data[p];
                if ((BYPASS != 0) && reg_write && (write_addr == read_addr[p]) &&
                    (write_addr != ADDR_WIDTH'(REG_ZERO))) begin
                    port_data[p] = write_data;
                end
                if (reset) begin
                    port_data[p] = '0;
                end
            end
        end
    endgenerate

    assign read_data_1 = port_data[0];
    assign read_data_2 = port_data[1];

endmodule

// File: tb/tb_register_file_32_by_32.sv
// Directed bench for register_file_32_by_32; a BYPASS=0 instance shares the stimulus.
module tb_register_file_32_by_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr_1;
    logic [4:0]  read_addr_2;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] nb_read_data_1;
    logic [31:0] nb_read_data_2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    register_file_32_by_32 #(.BYPASS(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .reg_write   (reg_write),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .read_addr_1 (read_addr_1),
        .read_addr_2 (read_addr_2),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2)
    );

    register_file_32_by_32 #(.BYPASS(0)) dut_nb (
        .clk         (clk),
        .reset       (reset),
        .reg_write   (reg_write),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .read_addr_1 (read_addr_1),
        .read_addr_2 (read_addr_2),
        .read_data_1 (nb_read_data_1),
        .read_data_2 (nb_read_data_2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        reg_write  = 1'b1;
        write_addr = addr;
        write_data = data;
        @(negedge clk);
        reg_write  = 1'b0;
    endtask

    task automatic read_regs(input logic [4:0] a1, input logic [4:0] a2);
        read_addr_1 = a1;
        read_addr_2 = a2;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        reg_write   = 1'b0;
        write_addr  = 5'd0;
        write_data  = 32'h0;
        read_addr_1 = 5'd5;
        read_addr_2 = 5'd31;
        #1;
        check("reset_rd1", read_data_1, 32'h0);
        check("reset_rd2", read_data_2, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Async reset clears loaded registers without a clock edge
        write_reg(5'd5, 32'hDEADBEEF);
        write_reg(5'd31, 32'h00000001);
        read_regs(5'd5, 5'd31);
        check("load_r5", read_data_1, 32'hDEADBEEF);
        check("load_r31", read_data_2, 32'h00000001);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_r5", read_data_1, 32'h0);
        check("async_rst_r31", read_data_2, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_r5", read_data_1, 32'h0);
        check("post_rst_r31", read_data_2, 32'h0);

        // Register 0 is never written nor bypassed
        @(negedge clk);
        reg_write  = 1'b1;
        write_addr = 5'd0;
        write_data = 32'hFFFFFFFF;
        read_regs(5'd0, 5'd0);
        check("r0_no_bypass", read_data_1, 32'h0);
        @(negedge clk);
        reg_write = 1'b0;
        #1;
        check("r0_rd1", read_data_1, 32'h0);
        check("r0_rd2", read_data_2, 32'h0);

        write_reg(5'd8, 32'hA5A5A5A5);
        write_reg(5'd9, 32'h5A5A5A5A);
        read_regs(5'd8, 5'd9);
        check("r8_rd1", read_data_1, 32'hA5A5A5A5);
        check("r9_rd2", read_data_2, 32'h5A5A5A5A);
        read_regs(5'd9, 5'd9);
        check("same_addr_rd1", read_data_1, 32'h5A5A5A5A);
        check("same_addr_rd2", read_data_2, 32'h5A5A5A5A);

        // Same-cycle bypass on port 1 only; port 2 reads a different entry
        write_reg(5'd3, 32'h11111111);
        @(negedge clk);
        reg_write  = 1'b1;
        write_addr = 5'd3;
        write_data = 32'h22222222;
        read_regs(5'd3, 5'd8);
        check("bypass_rd1", read_data_1, 32'h22222222);
        check("bypass_rd2_other", read_data_2, 32'hA5A5A5A5);
        check("nobypass_before", nb_read_data_1, 32'h11111111);
        @(negedge clk);
        reg_write = 1'b0;
        #1;
        check("bypass_after", read_data_1, 32'h22222222);
        check("nobypass_after", nb_read_data_1, 32'h22222222);

        // reg_write=0 holds everything, including with an unknown write address
        @(negedge clk);
        write_addr = 5'd7;
        write_data = 32'hCAFEBABE;
        repeat (3) @(negedge clk);
        write_addr = 'x;
        @(negedge clk);
        write_addr = 5'd0;
        read_regs(5'd7, 5'd8);
        check("hold_r7", read_data_1, 32'h0);
        check("hold_x_r8", read_data_2, 32'hA5A5A5A5);

        // Reset asserted in the same cycle as a write loses the write
        @(negedge clk);
        reg_write  = 1'b1;
        write_addr = 5'd4;
        write_data = 32'h12345678;
        #2;
        reset = 1'b1;
        @(negedge clk);
        reg_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        read_regs(5'd4, 5'd8);
        check("rst_write_r4", read_data_1, 32'h0);
        check("rst_cleared_r8", read_data_2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
